// File: rtl/glift_pkg.sv
// Shared GLIFT types: monitor FSM states and the shadow-logic mux used by tracked gates.
package glift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ALERT  = 2'd2,
    ST_LOCKED = 2'd3
  } glift_state_t;

  // Returns {o, o_t}; a tainted select leaks taint wherever the two inputs differ.
  function automatic logic [1:0] glift_mux_t(input logic sel, input logic sel_t,
                                             input logic a, input logic a_t,
                                             input logic b, input logic b_t);
    logic o;
    logic o_t;
    o   = sel ? a : b;
    o_t = sel_t ? (a_t | b_t | (a ^ b)) : (sel ? a_t : b_t);
    return {o, o_t};
  endfunction

endpackage

// File: rtl/glift_tracked_reg.sv
// Enabled register with GLIFT taint shadow; loads only on valid samples, one-cycle latency.
// No backpressure: every valid sample is consumed on the edge it is presented.
module glift_tracked_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             en,
  input  logic             en_t,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] d_t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_t
);
  import glift_pkg::*;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_t_q, q_t_d;

  always_comb begin
    q_d   = q_q;
    q_t_d = q_t_q;
    if (in_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        {q_d[i], q_t_d[i]} = glift_mux_t(en, en_t, d[i], d_t[i], q_q[i], q_t_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      q_t_q <= '0;
    end else begin
      q_q   <= q_d;
      q_t_q <= q_t_d;
    end
  end

  assign q   = q_q;
  assign q_t = q_t_q;

endmodule

// File: rtl/glift_taint_monitor.sv
// GLIFT sink: tracked register plus taint counters and an alert FSM; state/alert lag the sample by one cycle.
// No backpressure: every valid sample is consumed on the edge it is presented.
module glift_taint_monitor #(
  parameter int WIDTH  = 8,
  parameter int THRESH = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_data_t,
  input  logic             en,
  input  logic             en_t,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_t,
  output logic [CNT_W-1:0] taint_cnt,
  output logic             alert,
  output logic [1:0]       state
);
  import glift_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  glift_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_upd;
  logic [CNT_W-1:0] run_q, run_d, run_upd;
  logic             hit, clean;

  glift_tracked_reg #(.WIDTH(WIDTH)) u_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .en       (en),
    .en_t     (en_t),
    .d        (in_data),
    .d_t      (in_data_t),
    .q        (q),
    .q_t      (q_t)
  );

  always_comb begin
    hit     = in_valid & ((|in_data_t) | en_t);
    clean   = in_valid & ~hit;
    cnt_upd = cnt_q;
    if (hit && (cnt_q != CNT_MAX)) cnt_upd = cnt_q + ONE;

    // Run tracks tainted samples while armed, clean samples while alerting.
    run_upd = run_q;
    case (state_q)
      ST_IDLE, ST_ARMED: begin
        if (hit)        run_upd = (run_q == RUN_MAX) ? run_q : run_q + ONE;
        else if (clean) run_upd = '0;
      end
      ST_ALERT: begin
        if (clean)    run_upd = (run_q == RUN_MAX) ? run_q : run_q + ONE;
        else if (hit) run_upd = '0;
      end
      default: run_upd = run_q;
    endcase

    state_d = state_q;
    cnt_d   = cnt_upd;
    run_d   = run_upd;
    case (state_q)
      // The arming sample keeps its run contribution so THRESH hits alert from IDLE.
      ST_IDLE: if (in_valid) state_d = ST_ARMED;
      ST_ARMED: begin
        if (run_upd == RUN_MAX) begin
          state_d = ST_ALERT;
          run_d   = '0;
        end
      end
      ST_ALERT: begin
        if (cnt_upd == CNT_MAX) begin
          state_d = ST_LOCKED;
          run_d   = '0;
        end else if (run_upd == RUN_MAX) begin
          state_d = ST_ARMED;
          run_d   = '0;
        end
      end
      default: state_d = ST_LOCKED;
    endcase

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      run_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  assign taint_cnt = cnt_q;
  assign state     = state_q;
  assign alert     = (state_q == ST_ALERT) || (state_q == ST_LOCKED);

endmodule

// File: tb/tb_glift_taint_monitor.sv
// Scoreboarded bench for glift_taint_monitor: one default instance and one with a 3-bit counter.
module tb_glift_taint_monitor;

  typedef struct packed {
    logic       v, en, ent;
    logic [7:0] d, dt;
    logic       clr, rst;
  } stim_t;

  typedef struct packed {
    logic [7:0] q, qt, cnt;
    logic [1:0] st;
    logic       al;
  } obs_t;

  logic       clk;
  logic       rst, in_valid, en, en_t, clear;
  logic [7:0] in_data, in_data_t;
  logic [7:0] a_q, a_qt, a_cnt, b_q, b_qt;
  logic [2:0] b_cnt;
  logic       a_al, b_al;
  logic [1:0] a_st, b_st;

  int total = 0;
  int bad   = 0;

  stim_t plan[$];
  obs_t  plan_exp[$];
  obs_t  sb[$];

  glift_taint_monitor #(.WIDTH(8), .THRESH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_data_t(in_data_t),
    .en(en), .en_t(en_t), .clear(clear),
    .q(a_q), .q_t(a_qt), .taint_cnt(a_cnt), .alert(a_al), .state(a_st)
  );

  glift_taint_monitor #(.WIDTH(8), .THRESH(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_data_t(in_data_t),
    .en(en), .en_t(en_t), .clear(clear),
    .q(b_q), .q_t(b_qt), .taint_cnt(b_cnt), .alert(b_al), .state(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(logic v, logic e, logic et, logic [7:0] d, logic [7:0] dt,
                              logic c, logic r);
    stim_t s;
    s.v = v; s.en = e; s.ent = et; s.d = d; s.dt = dt; s.clr = c; s.rst = r;
    return s;
  endfunction

  function automatic stim_t tnt(logic [7:0] d);
    return S(1'b1, 1'b1, 1'b0, d, 8'h10, 1'b0, 1'b0);
  endfunction

  function automatic stim_t cln(logic [7:0] d);
    return S(1'b1, 1'b1, 1'b0, d, 8'h00, 1'b0, 1'b0);
  endfunction

  function automatic stim_t idl();
    return S(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
  endfunction

  // Alert is 1 exactly in ALERT (2) and LOCKED (3).
  function automatic obs_t mk(logic [7:0] q, logic [7:0] qt, logic [7:0] cnt, logic [1:0] st);
    obs_t o;
    o.q = q; o.qt = qt; o.cnt = cnt; o.st = st; o.al = (st == 2'd2) || (st == 2'd3);
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.q = a_q; o.qt = a_qt; o.cnt = a_cnt; o.st = a_st; o.al = a_al;
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.q = b_q; o.qt = b_qt; o.cnt = {5'b0, b_cnt}; o.st = b_st; o.al = b_al;
    return o;
  endfunction

  task automatic add(input stim_t s, input obs_t e);
    plan.push_back(s);
    plan_exp.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    in_valid = s.v; en = s.en; en_t = s.ent; in_data = s.d; in_data_t = s.dt;
    clear = s.clr; rst = s.rst;
    sb.push_back(plan_exp.pop_front());
  endtask

  task automatic test_reset();
    obs_t o, e;
    for (int i = 0; i < 2; i++)
      add(S(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'b1), mk(8'h00, 8'h00, 8'h00, 2'd0));
    for (int i = 0; plan.size() > 0; i++) begin
      drive(plan.pop_front());
      @(posedge clk); #1;
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset[%0d] got q=%h qt=%h cnt=%h st=%0d al=%b need q=%h qt=%h cnt=%h st=%0d al=%b",
                 i, o.q, o.qt, o.cnt, o.st, o.al, e.q, e.qt, e.cnt, e.st, e.al);
      end
    end
  endtask

  task automatic test_load_hold_glift();
    obs_t o, e;
    add(S(1'b1, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0), mk(8'hA5, 8'h00, 8'd0, 2'd1));
    add(S(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0), mk(8'hA5, 8'h00, 8'd0, 2'd1));
    add(S(1'b1, 1'b0, 1'b1, 8'h3C, 8'h01, 1'b0, 1'b0), mk(8'hA5, 8'h99, 8'd1, 2'd1));
    add(S(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0), mk(8'hA5, 8'h99, 8'd1, 2'd1));
    for (int i = 0; plan.size() > 0; i++) begin
      drive(plan.pop_front());
      @(posedge clk); #1;
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL load_glift[%0d] got q=%h qt=%h cnt=%h st=%0d al=%b need q=%h qt=%h cnt=%h st=%0d al=%b",
                 i, o.q, o.qt, o.cnt, o.st, o.al, e.q, e.qt, e.cnt, e.st, e.al);
      end
    end
  endtask

  task automatic test_alert_cycle();
    obs_t o, e;
    add(S(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1), mk(8'h00, 8'h00, 8'd0, 2'd0));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd1, 2'd1));
    add(idl(),      mk(8'h11, 8'h10, 8'd1, 2'd1));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd2, 2'd1));
    add(cln(8'h22), mk(8'h22, 8'h00, 8'd2, 2'd1));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd3, 2'd1));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd4, 2'd1));
    add(idl(),      mk(8'h11, 8'h10, 8'd4, 2'd1));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd5, 2'd1));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd6, 2'd2));
    add(cln(8'h22), mk(8'h22, 8'h00, 8'd6, 2'd2));
    add(idl(),      mk(8'h22, 8'h00, 8'd6, 2'd2));
    add(cln(8'h22), mk(8'h22, 8'h00, 8'd6, 2'd2));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd7, 2'd2));
    add(cln(8'h22), mk(8'h22, 8'h00, 8'd7, 2'd2));
    add(cln(8'h22), mk(8'h22, 8'h00, 8'd7, 2'd2));
    add(idl(),      mk(8'h22, 8'h00, 8'd7, 2'd2));
    add(cln(8'h22), mk(8'h22, 8'h00, 8'd7, 2'd2));
    add(cln(8'h22), mk(8'h22, 8'h00, 8'd7, 2'd1));
    for (int i = 0; plan.size() > 0; i++) begin
      drive(plan.pop_front());
      @(posedge clk); #1;
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL alert_cycle[%0d] got q=%h qt=%h cnt=%h st=%0d al=%b need q=%h qt=%h cnt=%h st=%0d al=%b",
                 i, o.q, o.qt, o.cnt, o.st, o.al, e.q, e.qt, e.cnt, e.st, e.al);
      end
    end
  endtask

  task automatic test_saturate_lock();
    obs_t o, e;
    add(S(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1), mk(8'h00, 8'h00, 8'd0, 2'd0));
    for (int k = 1; k <= 8; k++)
      add(tnt(8'h11), mk(8'h11, 8'h10, 8'((k > 7) ? 7 : k),
                         (k >= 7) ? 2'd3 : (k >= 4) ? 2'd2 : 2'd1));
    for (int k = 0; k < 5; k++)
      add(cln(8'h22), mk(8'h22, 8'h00, 8'd7, 2'd3));
    add(S(1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0), mk(8'h22, 8'h00, 8'd0, 2'd0));
    add(tnt(8'h11), mk(8'h11, 8'h10, 8'd1, 2'd1));
    for (int i = 0; plan.size() > 0; i++) begin
      drive(plan.pop_front());
      @(posedge clk); #1;
      o = obs_b(); e = sb.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL saturate_lock[%0d] got q=%h qt=%h cnt=%h st=%0d al=%b need q=%h qt=%h cnt=%h st=%0d al=%b",
                 i, o.q, o.qt, o.cnt, o.st, o.al, e.q, e.qt, e.cnt, e.st, e.al);
      end
    end
  endtask

  task automatic test_clear_priority();
    obs_t o, e;
    add(S(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1), mk(8'h00, 8'h00, 8'd0, 2'd0));
    for (int k = 1; k <= 4; k++)
      add(tnt(8'h11), mk(8'h11, 8'h10, 8'(k), (k == 4) ? 2'd2 : 2'd1));
    add(S(1'b1, 1'b1, 1'b1, 8'h55, 8'hFF, 1'b1, 1'b1), mk(8'h00, 8'h00, 8'd0, 2'd0));
    for (int k = 1; k <= 3; k++)
      add(tnt(8'h11), mk(8'h11, 8'h10, 8'(k), 2'd1));
    add(S(1'b1, 1'b1, 1'b0, 8'h33, 8'h10, 1'b1, 1'b0), mk(8'h33, 8'h10, 8'd0, 2'd0));
    for (int k = 1; k <= 4; k++)
      add(tnt(8'h11), mk(8'h11, 8'h10, 8'(k), (k == 4) ? 2'd2 : 2'd1));
    for (int i = 0; plan.size() > 0; i++) begin
      drive(plan.pop_front());
      @(posedge clk); #1;
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL clear_priority[%0d] got q=%h qt=%h cnt=%h st=%0d al=%b need q=%h qt=%h cnt=%h st=%0d al=%b",
                 i, o.q, o.qt, o.cnt, o.st, o.al, e.q, e.qt, e.cnt, e.st, e.al);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; en = 1'b0; en_t = 1'b0; clear = 1'b0;
    in_data = 8'h00; in_data_t = 8'h00;
    test_reset();
    test_load_hold_glift();
    test_alert_cycle();
    test_saturate_lock();
    test_clear_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
